hps_led_ctrl: RTL and testbench

HPS_LED_CTRL -- requirements
Module: hps_led_ctrl

---
 rtl/hps_led_pkg.sv | 31 +++
 rtl/led_prescaler.sv | 34 +++
 rtl/hps_led_ctrl.sv | 148 ++++++++++++++
 tb/tb_hps_led_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_led_pkg.sv
// Shared definitions for the HPS LED controller: register map, mode encoding
// and register field layout.
package hps_led_pkg;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_PATTERN = 2'd1;
   localparam logic [1:0] ADDR_TIMING  = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_STATIC = 2'b01,
      MODE_BLINK  = 2'b10,
      MODE_PWM    = 2'b11
   } led_mode_e;

   localparam int CTRL_MODE_LSB     = 0;
   localparam int CTRL_MODE_W       = 2;
   localparam int CTRL_IRQ_EN_BIT   = 2;

   localparam int TIMING_PERIOD_LSB = 0;
   localparam int TIMING_PERIOD_W   = 24;
   localparam int TIMING_DUTY_LSB   = 24;
   localparam int TIMING_DUTY_W     = 8;

   localparam int STATUS_TICK_BIT   = 0;
   localparam int STATUS_PHASE_BIT  = 1;

   localparam int PWM_CNT_W         = 8;

endpackage

// File: rtl/led_prescaler.sv
// Blink prescaler: down-counter that reloads from period at zero, giving a
// tick every period+1 cycles and toggling phase on each tick.
module led_prescaler #(
   parameter int PRESCALE_W = 24
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  tick,
   output logic                  phase
);

   logic [PRESCALE_W-1:0] cnt;

   // A reload from a register write takes precedence over a tick due in the same cycle.
   assign tick = (cnt == '0) && !load;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (load) begin
         cnt   <= period;
         phase <= 1'b0;
      end else if (cnt == '0) begin
         cnt   <= period;
         phase <= ~phase;
      end else begin
         cnt   <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/hps_led_ctrl.sv
// Avalon-MM LED controller for the HPS bridge: OFF/STATIC/BLINK/PWM drive of a
// pattern register, with a sticky blink tick that can raise an interrupt.
module hps_led_ctrl
   import hps_led_pkg::*;
#(
   parameter int LED_W      = 10,
   parameter int PRESCALE_W = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_readdatavalid,
   output logic [LED_W-1:0] leds,
   output logic             irq
);

   led_mode_e                  mode;
   logic                       irq_en;
   logic [LED_W-1:0]           pattern;
   logic [TIMING_PERIOD_W-1:0] period;
   logic [TIMING_DUTY_W-1:0]   duty;
   logic                       tick_sticky;
   logic [PWM_CNT_W-1:0]       pwm_cnt;

   logic                       wr_ctrl;
   logic                       wr_pattern;
   logic                       wr_timing;
   logic                       wr_status;
   logic                       pre_load;
   logic [PRESCALE_W-1:0]      pre_period;
   logic                       tick;
   logic                       phase;
   logic [LED_W-1:0]           leds_next;
   logic [31:0]                rd_mux;

   assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
   assign wr_pattern = avs_write && (avs_address == ADDR_PATTERN);
   assign wr_timing  = avs_write && (avs_address == ADDR_TIMING);
   assign wr_status  = avs_write && (avs_address == ADDR_STATUS);

   // A TIMING write must start the prescaler from the period being written, not the stale one.
   assign pre_load   = wr_ctrl || wr_timing;
   assign pre_period = wr_timing ? avs_writedata[TIMING_PERIOD_LSB +: PRESCALE_W]
                                 : period[PRESCALE_W-1:0];

   led_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (pre_load),
      .period  (pre_period),
      .tick    (tick),
      .phase   (phase)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mode    <= MODE_OFF;
         irq_en  <= 1'b0;
         pattern <= '0;
         period  <= '0;
         duty    <= '0;
      end else begin
         if (wr_ctrl) begin
            mode   <= led_mode_e'(avs_writedata[CTRL_MODE_LSB +: CTRL_MODE_W]);
            irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
         end
         if (wr_pattern) begin
            pattern <= avs_writedata[LED_W-1:0];
         end
         if (wr_timing) begin
            period <= avs_writedata[TIMING_PERIOD_LSB +: TIMING_PERIOD_W];
            duty   <= avs_writedata[TIMING_DUTY_LSB +: TIMING_DUTY_W];
         end
      end
   end

   // A tick arriving together with a W1C clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_sticky <= 1'b0;
      end else if (tick && (mode == MODE_BLINK)) begin
         tick_sticky <= 1'b1;
      end else if (wr_status && avs_writedata[STATUS_TICK_BIT]) begin
         tick_sticky <= 1'b0;
      end
   end

   assign irq = tick_sticky && irq_en;

   always_comb begin
      leds_next = '0;
      case (mode)
         MODE_STATIC: leds_next = pattern;
         MODE_BLINK:  leds_next = phase ? pattern : '0;
         MODE_PWM:    leds_next = (pwm_cnt < duty) ? pattern : '0;
         default:     leds_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
         leds    <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         leds    <= leds_next;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         ADDR_CTRL: begin
            rd_mux[CTRL_MODE_LSB +: CTRL_MODE_W] = mode;
            rd_mux[CTRL_IRQ_EN_BIT]              = irq_en;
         end
         ADDR_PATTERN: begin
            rd_mux[LED_W-1:0] = pattern;
         end
         ADDR_TIMING: begin
            rd_mux[TIMING_PERIOD_LSB +: TIMING_PERIOD_W] = period;
            rd_mux[TIMING_DUTY_LSB +: TIMING_DUTY_W]     = duty;
         end
         default: begin
            rd_mux[STATUS_TICK_BIT]  = tick_sticky;
            rd_mux[STATUS_PHASE_BIT] = phase;
         end
      endcase
   end

   // Read data is captured from pre-edge state, so a same-cycle write is not visible.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdata      <= avs_read ? rd_mux : 32'd0;
         avs_readdatavalid <= avs_read;
      end
   end

endmodule

// File: tb/tb_hps_led_ctrl.sv
// Bench for hps_led_ctrl: directed scenarios with literal expectations plus a
// randomized bus phase, all checked every cycle against a behavioural model.
module tb_hps_led_ctrl;

   localparam int LED_W      = 10;
   localparam int PRESCALE_W = 24;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       avs_address = 2'd0;
   logic             avs_read = 1'b0;
   logic             avs_write = 1'b0;
   logic [31:0]      avs_writedata = 32'd0;
   logic [31:0]      avs_readdata;
   logic             avs_readdatavalid;
   logic [LED_W-1:0] leds;
   logic             irq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hps_led_ctrl #(
      .LED_W      (LED_W),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .leds              (leds),
      .irq               (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the prescaler is described by the number of cycles
   // since the last reload (k) and the PWM counter by the cycles since reset.
   bit               m_valid = 1'b0;
   logic [1:0]       m_mode = 2'd0;
   logic             m_irq_en = 1'b0;
   logic [LED_W-1:0] m_pattern = '0;
   logic [23:0]      m_period = 24'd0;
   logic [7:0]       m_duty = 8'd0;
   logic             m_sticky = 1'b0;
   longint           m_k = 0;
   longint           m_age = 0;
   logic [LED_W-1:0] m_leds = '0;
   logic             m_rdv = 1'b0;
   logic [31:0]      m_rd = 32'd0;
   longint           p1;
   bit               m_ld, m_tk, m_ph;

   function automatic logic [31:0] reg_value(input logic [1:0] a, input bit ph);
      logic [31:0] v;
      v = 32'd0;
      case (a)
         2'd0: v = {29'd0, m_irq_en, m_mode};
         2'd1: v[LED_W-1:0] = m_pattern;
         2'd2: v = {m_duty, m_period};
         default: v = {30'd0, ph, m_sticky};
      endcase
      return v;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_valid   = 1'b1;
         m_mode    = 2'd0;
         m_irq_en  = 1'b0;
         m_pattern = '0;
         m_period  = 24'd0;
         m_duty    = 8'd0;
         m_sticky  = 1'b0;
         m_k       = 0;
         m_age     = 0;
         m_leds    = '0;
         m_rdv     = 1'b0;
         m_rd      = 32'd0;
      end else begin
         p1   = longint'(m_period) + 1;
         m_ld = avs_write && (avs_address == 2'd0 || avs_address == 2'd2);
         m_tk = ((m_k % p1) == (p1 - 1)) && !m_ld;
         m_ph = ((m_k / p1) % 2) == 1;
         case (m_mode)
            2'd0: m_leds = '0;
            2'd1: m_leds = m_pattern;
            2'd2: m_leds = m_ph ? m_pattern : '0;
            default: m_leds = (m_age[7:0] < m_duty) ? m_pattern : '0;
         endcase
         m_rdv = avs_read;
         m_rd  = avs_read ? reg_value(avs_address, m_ph) : 32'd0;
         if (m_tk && m_mode == 2'd2) m_sticky = 1'b1;
         else if (avs_write && avs_address == 2'd3 && avs_writedata[0]) m_sticky = 1'b0;
         if (avs_write) begin
            case (avs_address)
               2'd0: begin
                  m_mode   = avs_writedata[1:0];
                  m_irq_en = avs_writedata[2];
               end
               2'd1: m_pattern = avs_writedata[LED_W-1:0];
               2'd2: begin
                  m_period = avs_writedata[23:0];
                  m_duty   = avs_writedata[31:24];
               end
               default: ;
            endcase
         end
         m_k   = m_ld ? 0 : m_k + 1;
         m_age = m_age + 1;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_leds", {22'd0, leds}, {22'd0, m_leds});
         check("model_irq", {31'd0, irq}, {31'd0, m_sticky & m_irq_en});
         check("model_rdvalid", {31'd0, avs_readdatavalid}, {31'd0, m_rdv});
         check("model_rddata", avs_readdata, m_rd);
      end
   end

   // Bus tasks are entered on a falling edge and return on the next one.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic v);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d = avs_readdata;
      v = avs_readdatavalid;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        v;
      int          cnt;
      int          op;
      logic [1:0]  a;

      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      check("reset_leds", {22'd0, leds}, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("reset_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);

      // Static pattern and readback
      wr(2'd1, 32'h2AA);
      wr(2'd0, 32'h1);
      check("static_leds_lag", {22'd0, leds}, 32'd0);
      @(negedge clk);
      check("static_leds", {22'd0, leds}, 32'h2AA);
      rd(2'd1, d, v);
      check("pattern_rdvalid", {31'd0, v}, 32'd1);
      check("pattern_rddata", d, 32'h2AA);
      @(negedge clk);
      check("rdvalid_single", {31'd0, avs_readdatavalid}, 32'd0);
      check("rddata_idle", avs_readdata, 32'd0);

      // Blink with period 3: phase changes every 4 cycles
      wr(2'd2, 32'd3);
      wr(2'd0, 32'h6);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         check("blink_leds", {22'd0, leds}, (((j / 4) % 2) == 1) ? 32'h2AA : 32'd0);
      end
      check("blink_irq_set", {31'd0, irq}, 32'd1);
      rd(2'd3, d, v);
      check("status_tick", {31'd0, d[0]}, 32'd1);
      wr(2'd3, 32'h1);
      check("w1c_irq_clear", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("w1c_irq_hold", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_next_tick", {31'd0, irq}, 32'd1);
      repeat (3) @(negedge clk);
      wr(2'd3, 32'h1);
      check("w1c_vs_tick_irq", {31'd0, irq}, 32'd1);
      rd(2'd3, d, v);
      check("w1c_vs_tick_sticky", {31'd0, d[0]}, 32'd1);

      // PWM duty cycles
      wr(2'd1, 32'h3FF);
      wr(2'd2, {8'd64, 24'd0});
      wr(2'd0, 32'h3);
      @(negedge clk);
      cnt = 0;
      for (int j = 0; j < 256; j++) begin
         @(negedge clk);
         if (leds == 10'h3FF) cnt++;
      end
      check("pwm_duty64", cnt, 32'd64);
      wr(2'd2, {8'd255, 24'd0});
      @(negedge clk);
      cnt = 0;
      for (int j = 0; j < 256; j++) begin
         @(negedge clk);
         if (leds == 10'h3FF) cnt++;
      end
      check("pwm_duty255", cnt, 32'd255);
      wr(2'd2, 32'd0);
      @(negedge clk);
      cnt = 0;
      for (int j = 0; j < 256; j++) begin
         @(negedge clk);
         if (leds != '0) cnt++;
      end
      check("pwm_duty0", cnt, 32'd0);

      // Simultaneous read and write of PATTERN
      wr(2'd1, 32'h001);
      avs_address   = 2'd1;
      avs_writedata = 32'h100;
      avs_read      = 1'b1;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_read  = 1'b0;
      avs_write = 1'b0;
      check("rw_same_old", avs_readdata, 32'h001);
      rd(2'd1, d, v);
      check("rw_same_new", d, 32'h100);

      // Reset mid-blink with a read in flight
      wr(2'd2, 32'd3);
      wr(2'd0, 32'h6);
      repeat (6) @(negedge clk);
      reset_n     = 1'b0;
      avs_address = 2'd1;
      avs_read    = 1'b1;
      @(negedge clk);
      reset_n  = 1'b1;
      avs_read = 1'b0;
      check("rst_leds", {22'd0, leds}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
      check("rst_rddata", avs_readdata, 32'd0);
      @(negedge clk);
      check("rst_no_late_valid", {31'd0, avs_readdatavalid}, 32'd0);
      for (int r = 0; r < 3; r++) begin
         rd(2'(r), d, v);
         check("rst_reg_zero", d, 32'd0);
      end
      rd(2'd3, d, v);
      check("rst_sticky_zero", {31'd0, d[0]}, 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         op = int'($urandom_range(0, 19));
         a  = 2'($urandom_range(0, 3));
         d  = $urandom;
         if (a == 2'd2) d[23:0] = 24'($urandom_range(0, 12));
         if (a == 2'd3 && $urandom_range(0, 1) == 0) d[0] = 1'b0;
         avs_address   = a;
         avs_writedata = d;
         avs_read      = (op >= 8 && op <= 13) || op == 14;
         avs_write     = (op < 8) || op == 14;
         reset_n       = !(op == 19 && $urandom_range(0, 9) == 0);
         @(negedge clk);
         avs_read  = 1'b0;
         avs_write = 1'b0;
         reset_n   = 1'b1;
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
